gameplay: RTL and testbench



---
 rtl/gameplay_pkg.sv | 21 ++
 rtl/gameplay_if.sv | 41 ++++
 rtl/gameplay_counter.sv | 27 ++
 rtl/gameplay.sv | 58 +++++
 tb/tb_gameplay.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/gameplay_pkg.sv
// ----------------------------------------------------------------------------
// gameplay_pkg
// Shared types and constants for the Game-of-Life cell.
//   cell_state_t   : DEAD / ALIVE state encoding
//   COUNT_W        : width of the live-neighbour count (0..8 needs 4 bits)
//   CONWAY_BIRTH   : B3 mask, bit n = birth with n live neighbours
//   CONWAY_SURVIVE : S23 mask, bit n = survival with n live neighbours
// ----------------------------------------------------------------------------
package gameplay_pkg;

    typedef enum logic {
        DEAD  = 1'b0,
        ALIVE = 1'b1
    } cell_state_t;

    localparam int unsigned COUNT_W = 4;

    localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
    localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

endpackage

// File: rtl/gameplay_if.sv
// ----------------------------------------------------------------------------
// gameplay_if
// Signal bundle between a board driver (master) and one cell (slave).
//   neighbor       : 8 neighbour health bits, 1 = alive
//   health         : registered cell state, 1 = alive
//   neighbor_count : combinational live-neighbour count, 0..8
//   seed_valid     : load strobe        (only with GAMEPLAY_SEED_EN)
//   seed_value     : state to load      (only with GAMEPLAY_SEED_EN)
// ----------------------------------------------------------------------------
interface gameplay_if;
    import gameplay_pkg::*;

    logic [7:0]         neighbor;
    logic               health;
    logic [COUNT_W-1:0] neighbor_count;
`ifdef GAMEPLAY_SEED_EN
    logic               seed_valid;
    logic               seed_value;
`endif

    modport master (
        output neighbor,
`ifdef GAMEPLAY_SEED_EN
        output seed_valid,
        output seed_value,
`endif
        input  health,
        input  neighbor_count
    );

    modport slave (
        input  neighbor,
`ifdef GAMEPLAY_SEED_EN
        input  seed_valid,
        input  seed_value,
`endif
        output health,
        output neighbor_count
    );

endinterface

// File: rtl/gameplay_counter.sv
// ----------------------------------------------------------------------------
// counter
// Combinational popcount of the 8 neighbour bits as a three-level adder tree.
//   neighbor : 8 neighbour health bits
//   count    : number of set bits, 0..8, no saturation
// ----------------------------------------------------------------------------
module counter
    import gameplay_pkg::*;
(
    input  logic [7:0]         neighbor,
    output logic [COUNT_W-1:0] count
);

    logic [1:0] w_sum2 [4];
    logic [2:0] w_sum4 [2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
        assign w_sum2[gi] = {1'b0, neighbor[2*gi]} + {1'b0, neighbor[2*gi+1]};
    end

    for (genvar gj = 0; gj < 2; gj++) begin : g_lvl2
        assign w_sum4[gj] = {1'b0, w_sum2[2*gj]} + {1'b0, w_sum2[2*gj+1]};
    end

    assign count = {1'b0, w_sum4[0]} + {1'b0, w_sum4[1]};

endmodule

// File: rtl/gameplay.sv
// ----------------------------------------------------------------------------
// gameplay
// One Game-of-Life cell. Advances one generation per rising Clock edge using
// BIRTH_MASK / SURVIVE_MASK (default Conway B3/S23).
//   Clock : rising-edge clock
//   reset : synchronous, active-low; forces the cell DEAD (top priority)
//   bus   : gameplay_if.slave (neighbor in, health / neighbor_count out,
//           seed_valid / seed_value in when GAMEPLAY_SEED_EN is defined)
// Optional feature macro: GAMEPLAY_SEED_EN -- direct seed load of the state,
// priority reset > seed > rule.
// ----------------------------------------------------------------------------
module gameplay
    import gameplay_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = CONWAY_BIRTH,
    parameter logic [8:0] SURVIVE_MASK = CONWAY_SURVIVE
) (
    input  logic       Clock,
    input  logic       reset,
    gameplay_if.slave  bus
);

    cell_state_t        r_state;
    cell_state_t        w_next_state;
    logic [COUNT_W-1:0] w_count;

    counter u_counter (
        .neighbor (bus.neighbor),
        .count    (w_count)
    );

    always_ff @(posedge Clock) begin
        if (!reset) begin
            r_state <= DEAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = DEAD;
        case (r_state)
            DEAD:    w_next_state = BIRTH_MASK[w_count]   ? ALIVE : DEAD;
            ALIVE:   w_next_state = SURVIVE_MASK[w_count] ? ALIVE : DEAD;
            default: w_next_state = DEAD;
        endcase
`ifdef GAMEPLAY_SEED_EN
        // Seed overrides the rule; reset still wins in the state register.
        if (bus.seed_valid) begin
            w_next_state = bus.seed_value ? ALIVE : DEAD;
        end
`endif
    end

    assign bus.health         = (r_state == ALIVE);
    assign bus.neighbor_count = w_count;

endmodule

// File: tb/tb_gameplay.sv
// ----------------------------------------------------------------------------
// tb_gameplay
// Self-checking bench for the gameplay cell: a vector table of directed
// steps, an exhaustive 256-pattern sweep from each state, and seed-load
// sequences when GAMEPLAY_SEED_EN is defined. Expected health values are
// queued before each edge and compared after it.
// ----------------------------------------------------------------------------
module tb_gameplay;

    localparam logic [8:0] B_MASK = 9'b000001000;
    localparam logic [8:0] S_MASK = 9'b000001100;

    typedef struct {
        logic [7:0] nb;
        logic       rst_n;
        logic       exp_h;
        logic [3:0] exp_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic sb_q[$];
    vec_t vecs[18];

    gameplay_if u_if ();

    gameplay u_dut (
        .Clock (clk),
        .reset (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] pop8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) n = n + 4'd1;
        end
        return n;
    endfunction

    function automatic logic rule(input logic alive, input logic [3:0] n);
        return alive ? S_MASK[n] : B_MASK[n];
    endfunction

    task automatic check_cnt(input string name, input logic [3:0] exp_c);
        checks++;
        if (u_if.neighbor_count !== exp_c) begin
            failures++;
            $display("FAIL %s count: got=%0d required=%0d", name, u_if.neighbor_count, exp_c);
        end
    endtask

    task automatic check_health(input string name);
        logic exp_h;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s health: got=%b required=<queued value>", name, u_if.health);
        end else begin
            exp_h = sb_q.pop_front();
            if (u_if.health !== exp_h) begin
                failures++;
                $display("FAIL %s health: got=%b required=%b", name, u_if.health, exp_h);
            end
        end
    endtask

    // One clock: drive at negedge, check count, queue expected health,
    // check health 1 time unit after the rising edge.
    task automatic step(input string name, input logic [7:0] nb, input logic rn,
                        input logic exp_h, input logic [3:0] exp_c);
        @(negedge clk);
        rst_n       = rn;
        u_if.neighbor = nb;
        #1;
        check_cnt(name, exp_c);
        sb_q.push_back(exp_h);
        @(posedge clk);
        #1;
        check_health(name);
    endtask

`ifdef GAMEPLAY_SEED_EN
    task automatic seed_step(input string name, input logic [7:0] nb, input logic rn,
                             input logic sv, input logic sval, input logic exp_h);
        @(negedge clk);
        rst_n           = rn;
        u_if.neighbor   = nb;
        u_if.seed_valid = sv;
        u_if.seed_value = sval;
        sb_q.push_back(exp_h);
        @(posedge clk);
        #1;
        check_health(name);
        @(negedge clk);
        u_if.seed_valid = 1'b0;
        u_if.seed_value = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        u_if.neighbor = 8'h00;
`ifdef GAMEPLAY_SEED_EN
        u_if.seed_valid = 1'b0;
        u_if.seed_value = 1'b0;
`endif

        vecs[0]  = '{8'h07, 1'b0, 1'b0, 4'd3};   // reset wins over birth
        vecs[1]  = '{8'h07, 1'b1, 1'b1, 4'd3};   // birth on 3
        vecs[2]  = '{8'h01, 1'b1, 1'b0, 4'd1};   // underpopulation
        vecs[3]  = '{8'h01, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{8'h02, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{8'h02, 1'b1, 1'b0, 4'd1};
        vecs[6]  = '{8'h03, 1'b1, 1'b0, 4'd2};   // dead with 2 stays dead
        vecs[7]  = '{8'h03, 1'b1, 1'b0, 4'd2};
        vecs[8]  = '{8'h07, 1'b1, 1'b1, 4'd3};   // birth
        vecs[9]  = '{8'h03, 1'b1, 1'b1, 4'd2};   // survive on 2
        vecs[10] = '{8'h04, 1'b1, 1'b0, 4'd1};   // dies on 1
        vecs[11] = '{8'h07, 1'b1, 1'b1, 4'd3};
        vecs[12] = '{8'h3F, 1'b1, 1'b0, 4'd6};   // overcrowding
        vecs[13] = '{8'hFF, 1'b1, 1'b0, 4'd8};   // full count, no wrap
        vecs[14] = '{8'hFF, 1'b1, 1'b0, 4'd8};
        vecs[15] = '{8'h07, 1'b1, 1'b1, 4'd3};
        vecs[16] = '{8'h07, 1'b0, 1'b0, 4'd3};   // reset mid-run
        vecs[17] = '{8'h0C, 1'b1, 1'b0, 4'd2};   // prior ALIVE state discarded

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i].nb, vecs[i].rst_n,
                 vecs[i].exp_h, vecs[i].exp_cnt);
        end

        // Exhaustive sweep from each starting state against the B3/S23 model.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] nb;
                nb = 8'(v);
                step("sweep_rst", 8'h00, 1'b0, 1'b0, 4'd0);
                if (s == 1) step("sweep_birth", 8'h07, 1'b1, 1'b1, 4'd3);
                step($sformatf("sweep_s%0d_nb%02h", s, nb), nb, 1'b1,
                     rule(s == 1, pop8(nb)), pop8(nb));
            end
        end

`ifdef GAMEPLAY_SEED_EN
        step("seed_pre_rst", 8'h00, 1'b0, 1'b0, 4'd0);
        seed_step("seed_load1", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        step("seed_underpop", 8'h00, 1'b1, 1'b0, 4'd0);
        seed_step("seed_over_birth", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        seed_step("seed_load1b", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        seed_step("seed_vs_reset", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
